// File: rtl/axis_insert_header.sv
// AXI-Stream header inserter: prepends 1..DATA_BYTE_WD LSB-aligned header bytes and re-packs the payload.
// Optional build macro AXIS_INS_HDR_ZERO_PAD_EN forces data_out lanes with keep_out=0 to 0x00.
module axis_insert_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    valid_insert,
    output logic                    ready_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    input  logic [BYTE_CNT_WD:0]    byte_insert_cnt
);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

    localparam logic [DATA_BYTE_WD-1:0]  ALL_ONES = '1;
    localparam logic [BYTE_CNT_WD+1:0]   BYTES    = (BYTE_CNT_WD+2)'(DATA_BYTE_WD);

    state_t                  state, state_nxt;
    logic [DATA_WD-1:0]      res_q;
    logic [BYTE_CNT_WD:0]    r_q;
    logic [BYTE_CNT_WD+1:0]  flush_cnt_q;

    logic                    out_en, hdr_fire, in_fire, flush_fire;
    logic [BYTE_CNT_WD:0]    k_in;
    logic [BYTE_CNT_WD+1:0]  tot;
    logic [DATA_WD-1:0]      beat_data, beat_mask;
    logic [DATA_BYTE_WD-1:0] beat_keep;
    logic                    beat_last;
    logic [DATA_WD-1:0]      hdr_mask;
    int                      sh_res, sh_in;

    function automatic logic [DATA_BYTE_WD-1:0] keep_top(input int m);
        return ~(ALL_ONES >> m);
    endfunction

    // A transfer happens on a channel exactly when its valid and ready are both high on a rising edge;
    // valid/data are held by the sender until then, ready never depends on the same channel's valid.
    assign out_en       = !valid_out || ready_out;
    assign ready_insert = (state == IDLE) && !rst_n;
    assign ready_in     = (state == STREAM) && out_en && !rst_n;
    assign hdr_fire     = valid_insert && ready_insert;
    assign in_fire      = valid_in && ready_in;
    assign flush_fire   = (state == FLUSH) && out_en;

    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        k_in      = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (keep_in[i]) k_in = k_in + {{BYTE_CNT_WD{1'b0}}, 1'b1};
        tot       = {1'b0, r_q} + {1'b0, k_in};
        sh_res    = 8 * (DATA_BYTE_WD - int'(r_q));
        sh_in     = 8 * int'(r_q);
        beat_data = (res_q << sh_res) | (data_in >> sh_in);
        beat_keep = ALL_ONES;
        beat_last = 1'b0;
        hdr_mask  = '0;
        beat_mask = '0;

        unique case (state)
            IDLE: begin
                if (hdr_fire) state_nxt = STREAM;
            end
            STREAM: begin
                if (last_in) begin
                    if (tot <= BYTES) begin
                        beat_keep = keep_top(int'(tot));
                        beat_last = 1'b1;
                        if (in_fire) state_nxt = IDLE;
                    end else if (in_fire) begin
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Residual holds the tail of the last beat; its valid bytes are its top ones.
                beat_data = res_q << sh_res;
                beat_keep = keep_top(int'(flush_cnt_q));
                beat_last = 1'b1;
                if (out_en) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            hdr_mask[i*8 +: 8]  = {8{keep_insert[i]}};
            beat_mask[i*8 +: 8] = {8{beat_keep[i]}};
        end
`ifdef AXIS_INS_HDR_ZERO_PAD_EN
        beat_data = beat_data & beat_mask;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            valid_out   <= 1'b0;
            data_out    <= '0;
            keep_out    <= '0;
            last_out    <= 1'b0;
            res_q       <= '0;
            r_q         <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (hdr_fire) begin
                res_q <= data_insert & hdr_mask;
                r_q   <= byte_insert_cnt;
            end
            if (in_fire) begin
                res_q       <= data_in;
                flush_cnt_q <= tot - BYTES;
            end
            if (in_fire || flush_fire) begin
                valid_out <= 1'b1;
                data_out  <= beat_data;
                keep_out  <= beat_keep;
                last_out  <= beat_last;
            end else if (ready_out) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axis_insert_header.sv
// Directed bench for axis_insert_header: cycle-by-cycle stimulus with hand-computed output beats.
module tb_axis_insert_header;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        valid_out;
    logic        ready_out = 1'b1;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        valid_insert = 1'b0;
    logic        ready_insert;
    logic [31:0] data_insert = '0;
    logic [3:0]  keep_insert = '0;
    logic [2:0]  byte_insert_cnt = '0;

    int checks = 0;
    int errors = 0;

    axis_insert_header dut (
        .clk(clk), .rst_n(rst_n),
        .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
        .keep_in(keep_in), .last_in(last_in),
        .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
        .keep_out(keep_out), .last_out(last_out),
        .valid_insert(valid_insert), .ready_insert(ready_insert),
        .data_insert(data_insert), .keep_insert(keep_insert),
        .byte_insert_cnt(byte_insert_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{k[i]}};
        chk_bit({tag, "_valid"}, valid_out, 1'b1);
`ifdef AXIS_INS_HDR_ZERO_PAD_EN
        chk_word({tag, "_data"}, data_out, d);
`else
        chk_word({tag, "_data"}, data_out & m, d);
`endif
        chk_word({tag, "_keep"}, {28'b0, keep_out}, {28'b0, k});
        chk_bit({tag, "_last"}, last_out, l);
    endtask

    task automatic drive_header(input logic v, input logic [31:0] d, input logic [3:0] k, input logic [2:0] n);
        valid_insert    = v;
        data_insert     = d;
        keep_insert     = k;
        byte_insert_cnt = n;
    endtask

    task automatic drive_payload(input logic v, input logic [31:0] d, input logic [3:0] k, input logic l);
        valid_in = v;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
    endtask

    initial begin
        // reset
        rst_n = 1'b1;
        cyc(); cyc(); cyc();
        chk_bit("rst_valid_out", valid_out, 1'b0);
        chk_word("rst_data_out", data_out, 32'h0);
        chk_word("rst_keep_out", {28'b0, keep_out}, 32'h0);
        chk_bit("rst_last_out", last_out, 1'b0);
        chk_bit("rst_ready_in", ready_in, 1'b0);
        chk_bit("rst_ready_insert", ready_insert, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_bit("post_rst_ready_insert", ready_insert, 1'b1);

        // 3-byte header, three payload beats, flush beat
        drive_header(1'b1, 32'h00AABBCC, 4'b0111, 3'd3);
        #1;
        chk_bit("t1_hdr_ready_in", ready_in, 1'b0);
        cyc();
        drive_header(1'b0, 32'h0, 4'b0, 3'd0);
        drive_payload(1'b1, 32'h11223344, 4'b1111, 1'b0);
        #1;
        chk_bit("t1_ready_in", ready_in, 1'b1);
        chk_bit("t1_no_out_yet", valid_out, 1'b0);
        cyc();
        chk_beat("t1_b0", 32'hAABBCC11, 4'b1111, 1'b0);
        drive_payload(1'b1, 32'h55667788, 4'b1111, 1'b0);
        cyc();
        chk_beat("t1_b1", 32'h22334455, 4'b1111, 1'b0);
        drive_payload(1'b1, 32'h99AA0000, 4'b1100, 1'b1);
        cyc();
        chk_beat("t1_b2", 32'h66778899, 4'b1111, 1'b0);
        drive_payload(1'b0, 32'h0, 4'b0, 1'b0);
        #1;
        chk_bit("t1_flush_ready_in", ready_in, 1'b0);
        cyc();
        chk_beat("t1_b3", 32'hAA000000, 4'b1000, 1'b1);
        cyc();
        chk_bit("t1_drained", valid_out, 1'b0);

        // header and single last beat arrive together
        drive_header(1'b1, 32'h0000DDEE, 4'b0011, 3'd2);
        drive_payload(1'b1, 32'hF1F2F3F4, 4'b1000, 1'b1);
        #1;
        chk_bit("t2_hdr_cycle_ready_in", ready_in, 1'b0);
        chk_bit("t2_hdr_cycle_ready_insert", ready_insert, 1'b1);
        cyc();
        drive_header(1'b0, 32'h0, 4'b0, 3'd0);
        #1;
        chk_bit("t2_next_ready_in", ready_in, 1'b1);
        cyc();
        chk_beat("t2_b0", 32'hDDEEF100, 4'b1110, 1'b1);
        drive_payload(1'b0, 32'h0, 4'b0, 1'b0);
        cyc();
        chk_bit("t2_drained", valid_out, 1'b0);

        // output stall of two cycles mid-burst
        drive_header(1'b1, 32'h00AABBCC, 4'b0111, 3'd3);
        cyc();
        drive_header(1'b0, 32'h0, 4'b0, 3'd0);
        drive_payload(1'b1, 32'h11223344, 4'b1111, 1'b0);
        cyc();
        chk_beat("t3_b0", 32'hAABBCC11, 4'b1111, 1'b0);
        ready_out = 1'b0;
        drive_payload(1'b1, 32'h55667788, 4'b1111, 1'b0);
        #1;
        chk_bit("t3_stall0_ready_in", ready_in, 1'b0);
        cyc();
        chk_beat("t3_hold0", 32'hAABBCC11, 4'b1111, 1'b0);
        #1;
        chk_bit("t3_stall1_ready_in", ready_in, 1'b0);
        cyc();
        chk_beat("t3_hold1", 32'hAABBCC11, 4'b1111, 1'b0);
        ready_out = 1'b1;
        #1;
        chk_bit("t3_resume_ready_in", ready_in, 1'b1);
        cyc();
        chk_beat("t3_b1", 32'h22334455, 4'b1111, 1'b0);
        drive_payload(1'b1, 32'h99AA0000, 4'b1100, 1'b1);
        cyc();
        chk_beat("t3_b2", 32'h66778899, 4'b1111, 1'b0);
        drive_payload(1'b0, 32'h0, 4'b0, 1'b0);
        cyc();
        chk_beat("t3_b3", 32'hAA000000, 4'b1000, 1'b1);
        cyc();
        chk_bit("t3_drained", valid_out, 1'b0);

        // full-width header: pure prepend
        drive_header(1'b1, 32'hCAFEBABE, 4'b1111, 3'd4);
        cyc();
        drive_header(1'b0, 32'h0, 4'b0, 3'd0);
        drive_payload(1'b1, 32'h01020304, 4'b1111, 1'b1);
        cyc();
        chk_beat("t4_b0", 32'hCAFEBABE, 4'b1111, 1'b0);
        drive_payload(1'b0, 32'h0, 4'b0, 1'b0);
        cyc();
        chk_beat("t4_b1", 32'h01020304, 4'b1111, 1'b1);
        cyc();
        chk_bit("t4_drained", valid_out, 1'b0);

        // payload without header waits
        drive_payload(1'b1, 32'h12345678, 4'b1111, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_bit("t5_ready_in", ready_in, 1'b0);
            chk_bit("t5_valid_out", valid_out, 1'b0);
            cyc();
        end
        drive_payload(1'b0, 32'h0, 4'b0, 1'b0);

        // reset mid-packet, then a fresh 1-byte-header packet
        drive_header(1'b1, 32'h00AABBCC, 4'b0111, 3'd3);
        cyc();
        drive_header(1'b0, 32'h0, 4'b0, 3'd0);
        drive_payload(1'b1, 32'h11223344, 4'b1111, 1'b0);
        cyc();
        chk_beat("t6_pre_rst", 32'hAABBCC11, 4'b1111, 1'b0);
        rst_n = 1'b1;
        drive_payload(1'b1, 32'h55667788, 4'b1111, 1'b0);
        #1;
        chk_bit("t6_rst_ready_in", ready_in, 1'b0);
        chk_bit("t6_rst_ready_insert", ready_insert, 1'b0);
        cyc();
        chk_bit("t6_rst_valid_out", valid_out, 1'b0);
        chk_word("t6_rst_data_out", data_out, 32'h0);
        chk_word("t6_rst_keep_out", {28'b0, keep_out}, 32'h0);
        chk_bit("t6_rst_last_out", last_out, 1'b0);
        rst_n = 1'b0;
        drive_payload(1'b0, 32'h0, 4'b0, 1'b0);
        #1;
        chk_bit("t6_post_rst_ready_insert", ready_insert, 1'b1);
        chk_bit("t6_post_rst_ready_in", ready_in, 1'b0);
        drive_header(1'b1, 32'h00000077, 4'b0001, 3'd1);
        cyc();
        drive_header(1'b0, 32'h0, 4'b0, 3'd0);
        drive_payload(1'b1, 32'hA1B2C3D4, 4'b1111, 1'b1);
        cyc();
        chk_beat("t6_b0", 32'h77A1B2C3, 4'b1111, 1'b0);
        drive_payload(1'b0, 32'h0, 4'b0, 1'b0);
        cyc();
        chk_beat("t6_b1", 32'hD4000000, 4'b1000, 1'b1);
        cyc();
        chk_bit("t6_drained", valid_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_insert_header.md
# axis_insert_header

Streaming header inserter (RTL module `axis_insert_header`) that prepends a 1..DATA_BYTE_WD-byte header to each AXI-Stream packet and re-packs the payload so no empty byte lanes remain between header and payload. It sits between a packet source and an AXI-Stream sink. It is fully registered on the output side and sustains one beat per clock with no bubbles inside a burst.

## Interface
- DATA_WD, 32: data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD/8: bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD): byte-count base width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1).
- valid_in / ready_in  in / out  1  payload handshake.
- data_in  in  DATA_WD  payload; byte 0 of stream = MSB byte.
- keep_in  in  DATA_BYTE_WD  MSB-aligned contiguous keep; all-ones except on last beat.
- last_in  in  1  final payload beat.
- valid_out / ready_out  out / in  1  output handshake.
- data_out  out  DATA_WD  packed output data.
- keep_out  out  DATA_BYTE_WD  MSB-aligned contiguous keep.
- last_out  out  1  final output beat.
- valid_insert / ready_insert  in / out  1  header handshake.
- data_insert  in  DATA_WD  header; valid bytes are LSB-aligned.
- keep_insert  in  DATA_BYTE_WD  LSB-aligned contiguous keep (e.g. 0111).
- byte_insert_cnt  in  BYTE_CNT_WD+1  number of valid header bytes n, 1..DATA_BYTE_WD; must equal popcount(keep_insert).

## Operation
- States:
  - IDLE: ready_insert=1, ready_in=0.
  - STREAM: payload is accepted.
  - FLUSH: one residual output beat.
- IDLE → STREAM on valid_insert && ready_insert. Latch the n header bytes as the residual R; residual count r = n, constant for the packet.
- STREAM, payload beat D accepted:
  - Output beat = {R (r bytes), top DATA_BYTE_WD−r bytes of D}, keep all ones.
  - New R = low r bytes of D.
- Last beat with k valid bytes (popcount keep_in):
  - r+k ≤ DATA_BYTE_WD: single output beat {R, D top}, keep = top r+k bits, last_out=1 → IDLE.
  - Otherwise: full beat (last_out=0) → FLUSH.
- FLUSH: output R's top r+k−DATA_BYTE_WD valid bytes MSB-aligned, last_out=1, ready_in=0 → IDLE when loaded.
- r = DATA_BYTE_WD degenerates to a pure prepend: header beat, then payload delayed one beat.
- A payload arriving before its header waits with ready_in=0. A header and payload arriving together: header is taken first, payload the next cycle.
- A new header may be accepted in IDLE while the previous last beat still sits in the output register.

## Timing
- Output register: valid_out rises the cycle after the accepting handshake.
- ready_in = (state==STREAM) && (!valid_out || ready_out), combinational.
- Output stall: valid_out && !ready_out holds data_out/keep_out/last_out stable and drops ready_in in the same cycle.
- Burst with ready_out=1 and valid_in=1: one output beat per clock, no bubbles. The FLUSH beat adds exactly one cycle.
- ready_insert = (state==IDLE) && !rst_n-asserted.
- Reset: state=IDLE, valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0 while asserted.
- Reset mid-packet discards the partial packet and output register. The first cycle after reset has ready_insert=1.
- Illegal input (n=0, non-contiguous keep, partial keep without last): result undefined, no lockup; the next reset recovers.

## Configuration
- AXIS_INS_HDR_ZERO_PAD_EN defined: byte lanes of data_out with keep_out=0 are forced to 0x00.
- Undefined: those lanes carry stale shift-register contents (don't care). keep_out is identical in both builds.

## Test plan
- Header 0x00AABBCC, keep 0111, cnt 3, sent before the payload. Payload 0x11223344, 0x55667788, then last 0x99AA0000 keep 1100, ready_out=1. Required output:
  - 0xAABBCC11 / 1111
  - 0x22334455 / 1111
  - 0x66778899 / 1111
  - 0xAA000000 / 1000 last (zero-pad build), with no bubbles.
- Header 0x0000DDEE, keep 0011, cnt 2, same cycle as single last beat 0xF1F2F3F4 keep 1000 → one beat 0xDDEEF100 / 1110 last. ready_in is 0 in the header cycle and 1 in the next.
- ready_out low 2 cycles mid-burst → data_out held stable, ready_in=0 during the stall, no lost or duplicated beats afterwards.
- cnt 4 header 0xCAFEBABE, keep 1111, payload 0x01020304 last keep 1111 → 0xCAFEBABE / 1111, then 0x01020304 / 1111 last.
- valid_in held high in IDLE for 3 cycles with no header → ready_in=0, valid_out=0 throughout.
- Reset asserted mid-packet → all outputs at reset values next cycle. A fresh packet afterwards produces correct output.
